enc_pipe: RTL and testbench

Streaming systematic extended-Hamming encoder. It is the transmit-side counterpart of DEC and supports the same three code modes: 4/8, 11/16 and 26/32 (info/codeword bits).
- Two-stage pipeline with valid/ready handshakes on both sides.
- Mode travels with each word, so modes may change every cycle without draining.
- Output codeword layout is {info, parity}, zero-padded to MAX_CODEWORD_WIDTH. This is exactly the layout DEC consumes.

---
 rtl/enc_pkg.sv | 80 ++++++++
 rtl/enc_parity_calc.sv | 23 ++
 rtl/enc_pipe.sv | 112 +++++++++++
 tb/tb_enc_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared extended-Hamming code definitions: modes, field sizes and H-matrix columns.
// Imported by both the encoder and the decoder so the two sides build identical parity rows.
package enc_pkg;

   localparam int unsigned CW_W   = 32;
   localparam int unsigned INFO_W = 26;
   localparam int unsigned HB_W   = 5;

   localparam logic [1:0] MOD_4_8   = 2'b00;
   localparam logic [1:0] MOD_11_16 = 2'b01;
   localparam logic [1:0] MOD_26_32 = 2'b10;
   localparam logic [1:0] MOD_ILL   = 2'b11;

   localparam int unsigned K_4_8   = 4;
   localparam int unsigned P_4_8   = 4;
   localparam int unsigned N_4_8   = 8;
   localparam int unsigned K_11_16 = 11;
   localparam int unsigned P_11_16 = 5;
   localparam int unsigned N_11_16 = 16;
   localparam int unsigned K_26_32 = 26;
   localparam int unsigned P_26_32 = 6;
   localparam int unsigned N_26_32 = 32;

   typedef struct packed {
      logic [INFO_W-1:0] info;
      logic [1:0]        mode;
      logic [HB_W-1:0]   hbits;
      logic              err;
   } s1_t;

   // i-th integer >= 3 that is not a power of two
   function automatic int unsigned info_col(input int unsigned i);
      int unsigned n;
      int unsigned col;
      n   = 0;
      col = 0;
      for (int unsigned c = 3; c < 64; c++) begin
         if ((c & (c - 1)) != 0) begin
            if (n == i && col == 0) col = c;
            n++;
         end
      end
      return col;
   endfunction

   // info bits participating in Hamming bit j
   function automatic logic [INFO_W-1:0] row_mask(input int unsigned j);
      logic [INFO_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < INFO_W; i++) begin
         m[i] = ((info_col(i) >> j) & 32'd1) != 32'd0;
      end
      return m;
   endfunction

   function automatic logic [INFO_W-1:0] info_mask(input logic [1:0] mode);
      logic [INFO_W-1:0] m;
      m = '0;
      case (mode)
         MOD_4_8:   m[K_4_8-1:0]   = '1;
         MOD_11_16: m[K_11_16-1:0] = '1;
         MOD_26_32: m              = '1;
         default:   m              = '0;
      endcase
      return m;
   endfunction

   function automatic logic [HB_W-1:0] hbit_mask(input logic [1:0] mode);
      logic [HB_W-1:0] m;
      m = '0;
      case (mode)
         MOD_4_8:   m[P_4_8-2:0]   = '1;
         MOD_11_16: m[P_11_16-2:0] = '1;
         MOD_26_32: m[P_26_32-2:0] = '1;
         default:   m              = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/enc_parity_calc.sv
// Combinational Hamming-bit generator: masked info and mode in, parity[P-2:0] out.
// Bits above P-2 for the selected mode are forced to zero.
module enc_parity_calc
   import enc_pkg::*;
(
   input  logic [INFO_W-1:0] info,
   input  logic [1:0]        mode,
   output logic [HB_W-1:0]   hbits
);

   logic [INFO_W-1:0] info_m;
   logic [HB_W-1:0]   raw;

   assign info_m = info & info_mask(mode);

   for (genvar j = 0; j < HB_W; j++) begin : g_row
      localparam logic [INFO_W-1:0] ROW = row_mask(j);
      assign raw[j] = ^(info_m & ROW);
   end

   assign hbits = raw & hbit_mask(mode);

endmodule

// File: rtl/enc_pipe.sv
// Two-stage streaming extended-Hamming encoder (4/8, 11/16, 26/32) with valid/ready on both sides.
// S1 registers masked info plus Hamming bits; S2 adds the overall parity and assembles {info, parity}.
module enc_pipe
   import enc_pkg::*;
#(
   parameter int unsigned MAX_CODEWORD_WIDTH = 32,
   parameter int unsigned MAX_INFO_WIDTH     = 26,
   parameter int unsigned CNT_WIDTH          = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
   input  logic [1:0]                    work_mod,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
   output logic [1:0]                    out_mod,
   output logic                          out_err,
   output logic [CNT_WIDTH-1:0]          word_cnt
);

   logic                          live;
   logic                          s1_v;
   logic                          s2_v;
   s1_t                           s1_q;
   s1_t                           s1_d;
   logic [MAX_INFO_WIDTH-1:0]     info_in;
   logic [HB_W-1:0]               hb;
   logic                          s2_free;
   logic                          s1_adv;
   logic                          in_fire;
   logic                          out_fire;
   logic                          ovr;
   logic [MAX_CODEWORD_WIDTH-1:0] cw;
   logic                          unused_hi;

   assign unused_hi = ^data_in[MAX_CODEWORD_WIDTH-1:MAX_INFO_WIDTH];

   // live keeps in_ready low during reset and releases it one edge later
   assign s2_free   = !s2_v || out_ready;
   assign in_ready  = live && (!s1_v || s2_free);
   assign s1_adv    = s1_v && s2_free;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = s2_v;
   assign out_fire  = s2_v && out_ready;

   assign info_in = data_in[MAX_INFO_WIDTH-1:0] & info_mask(work_mod);

   enc_parity_calc u_parity (
      .info  (info_in),
      .mode  (work_mod),
      .hbits (hb)
   );

   always_comb begin
      s1_d       = '0;
      s1_d.info  = info_in;
      s1_d.mode  = work_mod;
      s1_d.hbits = hb;
      s1_d.err   = (work_mod == MOD_ILL);
   end

   // info and unused hbits are already zero, so one reduction serves every mode
   always_comb begin
      cw  = '0;
      ovr = ^{s1_q.info, s1_q.hbits};
      case (s1_q.mode)
         MOD_4_8:   cw[N_4_8-1:0]   = {s1_q.info[K_4_8-1:0], ovr, s1_q.hbits[P_4_8-2:0]};
         MOD_11_16: cw[N_11_16-1:0] = {s1_q.info[K_11_16-1:0], ovr, s1_q.hbits[P_11_16-2:0]};
         MOD_26_32: cw[N_26_32-1:0] = {s1_q.info[K_26_32-1:0], ovr, s1_q.hbits[P_26_32-2:0]};
         default:   cw              = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         live     <= 1'b0;
         s1_v     <= 1'b0;
         s1_q     <= '0;
         s2_v     <= 1'b0;
         data_out <= '0;
         out_mod  <= '0;
         out_err  <= 1'b0;
         word_cnt <= '0;
      end else begin
         live <= 1'b1;

         if (in_fire) begin
            s1_v <= 1'b1;
            s1_q <= s1_d;
         end else if (s1_adv) begin
            s1_v <= 1'b0;
         end

         if (s1_adv) begin
            s2_v     <= 1'b1;
            data_out <= cw;
            out_mod  <= s1_q.mode;
            out_err  <= s1_q.err;
         end else if (out_fire) begin
            s2_v <= 1'b0;
         end

         if (out_fire && word_cnt != '1) begin
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_enc_pipe.sv
// Directed self-checking bench for enc_pipe: spec vectors, streaming, backpressure, illegal mode, reset.
module tb_enc_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] data_in;
   logic [1:0]  work_mod;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] data_out;
   logic [1:0]  out_mod;
   logic        out_err;
   logic [15:0] word_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   enc_pipe #(
      .MAX_CODEWORD_WIDTH (32),
      .MAX_INFO_WIDTH     (26),
      .CNT_WIDTH          (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .work_mod  (work_mod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_mod   (out_mod),
      .out_err   (out_err),
      .word_cnt  (word_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference encoder: walks columns sequentially and accumulates a syndrome
   function automatic logic [31:0] ref_enc(input logic [1:0] m, input logic [31:0] d);
      int unsigned k, p, col;
      logic [5:0]  syn;
      logic        ov;
      logic [31:0] info, par, cw;
      if (m == 2'b11) return 32'h0;
      k = (m == 2'b00) ? 4 : (m == 2'b01) ? 11 : 26;
      p = k == 4 ? 4 : k == 11 ? 5 : 6;
      col = 3;
      syn = '0;
      ov  = 1'b0;
      for (int unsigned i = 0; i < k; i++) begin
         while ((col & (col - 1)) == 0) col++;
         if (d[i]) begin
            syn = syn ^ col[5:0];
            ov  = ~ov;
         end
         col++;
      end
      par  = 32'(syn) & ((32'd1 << (p - 1)) - 32'd1);
      ov   = ov ^ (^par);
      info = d & ((32'd1 << k) - 32'd1);
      cw   = (info << p) | (32'(ov) << (p - 1)) | par;
      return cw;
   endfunction

   logic [31:0] exp_d [10];
   logic [1:0]  exp_m [10];
   logic [31:0] held;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; data_in = '0; work_mod = '0; out_ready = 1'b0;
      #3;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      step(); step();
      chk("rst_in_ready_clk", in_ready, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_out_err", out_err, 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("post_rst_in_ready", in_ready, 1);

      // Mode 4/8 sequence
      out_ready = 1'b1;
      in_valid = 1'b1; work_mod = 2'b00; data_in = 32'h1;
      step();
      chk("m00_early_valid", out_valid, 0);
      data_in = 32'hF;
      step();
      chk("m00_w0_valid", out_valid, 1);
      chk("m00_w0", data_out, 32'h0000_001B);
      chk("m00_w0_mod", out_mod, 2'b00);
      data_in = 32'h0;
      step();
      chk("m00_w1", data_out, 32'h0000_00FF);
      in_valid = 1'b0;
      step();
      chk("m00_w2", data_out, 32'h0);
      chk("m00_w2_valid", out_valid, 1);
      step();
      chk("m00_drained", out_valid, 0);
      chk("m00_cnt", word_cnt, 3);

      // Modes 11/16 and 26/32 with garbage above K
      in_valid = 1'b1; work_mod = 2'b01; data_in = 32'hFFFF_F801;
      step();
      work_mod = 2'b10; data_in = 32'hFC00_0001;
      step();
      chk("m01_w", data_out, 32'h0000_0033);
      chk("m01_mod", out_mod, 2'b01);
      in_valid = 1'b0;
      step();
      chk("m10_w", data_out, 32'h0000_0063);
      chk("m10_mod", out_mod, 2'b10);
      step();
      chk("m_cnt", word_cnt, 5);

      // Back-to-back ten words, cycling modes
      for (int i = 0; i < 10; i++) begin
         exp_m[i] = 2'(i % 3);
         exp_d[i] = ref_enc(exp_m[i], (32'h0137_5BD9 * 32'(i + 1)) ^ 32'hDEAD_BEEF);
      end
      for (int j = 0; j <= 10; j++) begin
         if (j < 10) begin
            in_valid = 1'b1;
            work_mod = 2'(j % 3);
            data_in  = (32'h0137_5BD9 * 32'(j + 1)) ^ 32'hDEAD_BEEF;
            #0;
            chk("b2b_in_ready", in_ready, 1);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (j >= 1) begin
            chk("b2b_valid", out_valid, 1);
            chk("b2b_data", data_out, exp_d[j-1]);
            chk("b2b_mod", out_mod, exp_m[j-1]);
         end
      end
      step();
      chk("b2b_cnt", word_cnt, 15);
      chk("b2b_drained", out_valid, 0);

      // Backpressure: three words offered over five stalled cycles
      out_ready = 1'b0;
      in_valid = 1'b1; work_mod = 2'b01; data_in = 32'h123;
      step();
      work_mod = 2'b10; data_in = 32'h02AB_CDEF;
      step();
      work_mod = 2'b00; data_in = 32'h9;
      #0;
      chk("bp_in_ready_low", in_ready, 0);
      held = data_out;
      chk("bp_w0", data_out, ref_enc(2'b01, 32'h123));
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp_in_ready_hold", in_ready, 0);
         chk("bp_stable", data_out, held);
         chk("bp_valid_hold", out_valid, 1);
      end
      chk("bp_cnt_hold", word_cnt, 15);
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("bp_w1", data_out, ref_enc(2'b10, 32'h02AB_CDEF));
      chk("bp_w1_mod", out_mod, 2'b10);
      step();
      chk("bp_w2", data_out, ref_enc(2'b00, 32'h9));
      step();
      chk("bp_no_dup", out_valid, 0);
      chk("bp_cnt", word_cnt, 18);

      // Illegal mode then legal word
      in_valid = 1'b1; work_mod = 2'b11; data_in = 32'hFFFF_FFFF;
      step();
      work_mod = 2'b00; data_in = 32'h1;
      step();
      in_valid = 1'b0;
      chk("ill_data", data_out, 0);
      chk("ill_err", out_err, 1);
      chk("ill_valid", out_valid, 1);
      chk("ill_mod", out_mod, 2'b11);
      step();
      chk("ill_next_data", data_out, 32'h0000_001B);
      chk("ill_next_err", out_err, 0);
      step();
      chk("ill_cnt", word_cnt, 20);

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1; work_mod = 2'b10; data_in = 32'h3;
      step();
      data_in = 32'h7;
      step();
      in_valid = 1'b0;
      chk("ar_full_valid", out_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_in_ready", in_ready, 0);
      chk("ar_word_cnt", word_cnt, 0);
      chk("ar_data_out", data_out, 0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("ar_post_ready", in_ready, 1);
      chk("ar_post_valid", out_valid, 0);
      out_ready = 1'b1;
      in_valid = 1'b1; work_mod = 2'b01; data_in = 32'h5;
      step();
      in_valid = 1'b0;
      chk("ar_lat1", out_valid, 0);
      step();
      chk("ar_lat2", out_valid, 1);
      chk("ar_data", data_out, 32'h0000_00A5);
      step();
      chk("ar_cnt", word_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
